// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M/RV64M multiply/divide unit.
// A radix-2 shift-add multiplier and a restoring divider share one
// accumulator pair {acc_hi, acc_lo}. An op takes XLEN step cycles plus
// one sign-correction cycle. Divide-by-zero and signed overflow finish
// straight from IDLE.
// Optional build macro MULDIV_EARLY_OUT_EN: also finishes trivial
// multiplies (a zero operand) and divides with |rs1| < |rs2| straight
// from IDLE. Results are the same with or without it.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_n;
  logic [2:0]           op_q;
  logic [TAG_W-1:0]     tag_q;
  logic [CNT_W-1:0]     cnt;
  logic                 neg_q;
  logic [XLEN-1:0]      acc_hi, acc_lo, opb;
  logic [XLEN-1:0]      result_q;

  // Two's-complement magnitude/sign helpers.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Operand decode on the request side.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, div_ovf, accept;

  assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_neg    = a_signed & rs1_val[XLEN-1];
  assign b_neg    = b_signed & rs2_val[XLEN-1];
  assign a_abs    = cond_neg(rs1_val, a_neg);
  assign b_abs    = cond_neg(rs2_val, b_neg);
  assign div_zero = op[2] && (rs2_val == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (rs1_val == MIN_NEG) && (rs2_val == '1);
  assign accept   = (state == IDLE) && in_valid && !flush;

  // Results that need no iteration: op[1] distinguishes REM* from DIV*.
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;
  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    if (div_zero) begin
      fast_hit = 1'b1;
      fast_res = op[1] ? rs1_val : '1;
    end else if (div_ovf) begin
      fast_hit = 1'b1;
      fast_res = op[1] ? '0 : rs1_val;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (!op[2] && ((rs1_val == '0) || (rs2_val == '0))) begin
      fast_hit = 1'b1;
      fast_res = '0;
    end else if (op[2] && (a_abs < b_abs)) begin
      fast_hit = 1'b1;
      fast_res = op[1] ? rs1_val : '0;
    end
`endif
  end

  // One iteration step of the shared datapath plus the final sign fix-up.
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_diff, acc_hi_step, acc_lo_step;
  logic              div_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   final_res;
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb : '0)};
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opb};
    div_diff  = div_shift[XLEN-1:0] - opb;
    if (op_q[2]) begin
      acc_hi_step = div_ge ? div_diff : div_shift[XLEN-1:0];
      acc_lo_step = {acc_lo[XLEN-2:0], div_ge};
    end else begin
      acc_hi_step = mul_sum[XLEN:1];
      acc_lo_step = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
    prod = cond_neg2({acc_hi, acc_lo}, neg_q);
    if (op_q[2])
      final_res = cond_neg(op_q[1] ? acc_hi : acc_lo, neg_q);
    else
      final_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept) state_n = fast_hit ? DONE : CALC;
      end
      CALC: begin
        if (flush)            state_n = IDLE;
        else if (cnt == '0)   state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, iteration and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      tag_q    <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q   <= op;
      tag_q  <= tag_in;
      cnt    <= CNT_W'(XLEN);
      neg_q  <= (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
      acc_hi <= '0;
      acc_lo <= op[2] ? a_abs : b_abs;
      opb    <= op[2] ? b_abs : a_abs;
      if (fast_hit) result_q <= fast_res;
    end else if ((state == CALC) && !flush) begin
      if (cnt != '0) begin
        acc_hi <= acc_hi_step;
        acc_lo <= acc_lo_step;
        cnt    <= cnt - CNT_W'(1);
      end else begin
        result_q <= final_res;
      end
    end
  end

  assign result  = result_q;
  assign tag_out = tag_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and randomized bench for muldiv_seq (XLEN=32).
// A cycle-level reference model decides what in_ready/out_valid/busy,
// result and tag_out must be each cycle from the RV32M rules.
module tb_muldiv_seq;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = '0;
  logic [XLEN-1:0]  rs1_val = '0;
  logic [XLEN-1:0]  rs2_val = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;
  logic             busy;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val), .tag_in(tag_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .tag_out(tag_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RV32M result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'(b);
    p  = '0;
    case (o)
      3'd0: begin p = 64'(a) * 64'(b); return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = 64'(a) * 64'(b); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Ops that finish straight from IDLE instead of iterating.
  function automatic bit is_short(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    if (o >= 3'd4 && b == 0) return 1'b1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
    if (o < 3'd4 && (a == 0 || b == 0)) return 1'b1;
    if (o >= 3'd4) begin
      if (o == 3'd4 || o == 3'd6) begin
        ma = longint'($signed(a)); mb = longint'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
      end else begin
        ma = longint'(a); mb = longint'(b);
      end
      if (ma < mb) return 1'b1;
    end
`else
    ma = 0; mb = 0;
    if (ma != mb) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Reference model: 0 idle, 1 iterating, 2 result presented.
  int               m_state = 0;
  int               m_rem = 0;
  logic [XLEN-1:0]  m_res = '0;
  logic [TAG_W-1:0] m_tag = '0;

  // Compare process: outputs are stable at the falling edge; inputs seen
  // here are the ones the next rising edge will sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_state = 0;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_result", result, 0);
      chk("reset_tag_out", tag_out, 0);
    end else begin
      chk("in_ready", in_ready, m_state == 0);
      chk("out_valid", out_valid, m_state == 2);
      chk("busy", busy, m_state != 0);
      if (m_state == 2) begin
        chk("result", result, m_res);
        chk("tag_out", tag_out, m_tag);
      end
      case (m_state)
        0: if (in_valid && !flush) begin
          m_res = ref_res(op, rs1_val, rs2_val);
          m_tag = tag_in;
          if (is_short(op, rs1_val, rs2_val)) m_state = 2;
          else begin m_state = 1; m_rem = XLEN + 1; end
        end
        1: if (flush) m_state = 0;
           else begin
             m_rem--;
             if (m_rem == 0) m_state = 2;
           end
        default: if (flush || out_ready) m_state = 0;
      endcase
    end
  end

  // Issue one op (called just after a rising edge, in IDLE), returning the
  // number of rising edges after the accepting edge until out_valid.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, input int hold, output int lat);
    int n;
    out_ready = (hold == 0);
    in_valid = 1'b1; op = o; rs1_val = a; rs2_val = b; tag_in = t;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #2; n++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #2;
    // Scramble the inputs after the accept edge; they must not matter.
    in_valid = 1'($urandom_range(0, 1));
    op = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom; tag_in = TAG_W'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #2; lat++;
      in_valid = 1'($urandom_range(0, 1));
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    chk("latency", lat, is_short(o, a, b) ? 0 : XLEN + 1);
    repeat (hold) begin @(posedge clk); #2; in_valid = 1'($urandom_range(0, 1)); end
    out_ready = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      6: return 32'h0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [2:0] ro;
    logic [31:0] ra, rb;

    // Pin the reference model to hand-computed values.
    chk("pin_mul", ref_res(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("pin_mulh", ref_res(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("pin_mulhu", ref_res(3'd3, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("pin_mulhsu", ref_res(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    chk("pin_div", ref_res(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem", ref_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_divu", ref_res(3'd5, 32'd100, 32'd7), 32'd14);
    chk("pin_remu", ref_res(3'd7, 32'd100, 32'd7), 32'd2);
    chk("pin_div0", ref_res(3'd4, 32'd100, 32'd0), 32'hFFFF_FFFF);
    chk("pin_rem0", ref_res(3'd6, 32'd100, 32'd0), 32'd100);
    chk("pin_divovf", ref_res(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("pin_removf", ref_res(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 0, lat);
    chk("mul_latency_33", lat, 33);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 0, lat);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd5, 0, lat);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, 0, lat);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, lat);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 0, lat);
    run_op(3'd5, 32'd100, 32'd7, 5'd9, 0, lat);
    run_op(3'd7, 32'd100, 32'd7, 5'd10, 0, lat);
    run_op(3'd4, 32'd100, 32'd0, 5'd11, 0, lat);
    chk("div0_short", lat, 0);
    run_op(3'd6, 32'd100, 32'd0, 5'd12, 0, lat);
    chk("rem0_short", lat, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, lat);
    chk("divovf_short", lat, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0, lat);
    chk("removf_short", lat, 0);

    // Stall in DONE, then issue the next op with no gap.
    run_op(3'd5, 32'd1000, 32'd9, 5'd15, 10, lat);
    chk("after_release_in_ready", in_ready, 1);
    run_op(3'd7, 32'd1000, 32'd9, 5'd16, 0, lat);

    // Flush at the fifth CALC cycle.
    in_valid = 1'b1; op = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd3; tag_in = 5'd17;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    chk("flush_calc_out_valid", out_valid, 0);
    chk("flush_calc_in_ready", in_ready, 1);

    // Flush beats in_valid in IDLE.
    in_valid = 1'b1; flush = 1'b1; op = 3'd0; rs1_val = 32'd3; rs2_val = 32'd3;
    @(posedge clk); #2;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", busy, 0);

    // Flush while a result waits in DONE.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd5; rs1_val = 32'd5; rs2_val = 32'd0; tag_in = 5'd18;
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("done_out_valid", out_valid, 1);
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0; out_ready = 1'b1;
    chk("flush_done_out_valid", out_valid, 0);

    // Asynchronous reset in the middle of an iteration.
    in_valid = 1'b1; op = 3'd1; rs1_val = $urandom; rs2_val = $urandom; tag_in = 5'd19;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_result", result, 0);
    chk("async_rst_tag_out", tag_out, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Randomized ops against the model.
    for (int i = 0; i < 80; i++) begin
      ro = 3'($urandom);
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, TAG_W'($urandom), ($urandom_range(0, 5) == 0) ? 3 : 0, lat);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
